axi_fifo_slave: RTL and testbench

Bus-side endpoint of the packet switch: terminates an `axi_bus.Slave` port and bridges it to a pair of ready/valid word streams. CPU writes to the DATA register push words into a TX FIFO that drains onto the switch ingress stream. CPU reads of DATA pop words from an RX FIFO filled by the switch egress stream. STATUS and CTRL registers expose FIFO levels, a sticky underflow flag and flush controls.

---
 rtl/axi_fifo_pkg.sv | 23 ++
 rtl/axi_bus.sv | 26 ++
 rtl/axi_fifo_slave_sync_fifo.sv | 51 +++++
 rtl/axi_fifo_slave.sv | 171 +++++++++++++++++
 tb/tb_axi_fifo_slave.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_fifo_pkg.sv
// Shared register map, CTRL/STATUS field layout and FSM state type for the bus FIFO endpoint.
package axi_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;

  localparam int STAT_TX_LVL_LSB    = 0;
  localparam int STAT_RX_LVL_LSB    = 12;
  localparam int STAT_LVL_W         = 12;
  localparam int STAT_UNDERFLOW_BIT = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WDAT = 2'd1,
    RRSP = 2'd2
  } axi_fifo_state_t;

endpackage

// File: rtl/axi_bus.sv
// Simple single-outstanding CPU bus: address phase, then either a write-data or read-response phase.
interface axi_bus #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  logic                      avalid;
  logic                      aready;
  logic                      awrite;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic                      wvalid;
  logic                      wready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic                      rvalid;
  logic                      rready;

  modport Slave (
    input  avalid, awrite, addr, wdata, wvalid, rready,
    output aready, wready, rdata, rvalid
  );

  modport Master (
    output avalid, awrite, addr, wdata, wvalid, rready,
    input  aready, wready, rdata, rvalid
  );
endinterface

// File: rtl/axi_fifo_slave_sync_fifo.sv
// Single-clock FIFO with registered pointers; flush empties it and overrides any push/pop that cycle.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // pointers carry one extra wrap bit so full and empty differ
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_fifo_slave.sv
// CPU bus endpoint bridging DATA writes to a TX stream and DATA reads from an RX stream.
// state | meaning
// IDLE  | address phase open, decode and read side effects happen here
// WDAT  | waiting for write data (stalls on DATA while TX is full)
// RRSP  | read response held until accepted
module axi_fifo_slave
  import axi_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_bus.Slave                 s_axi,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);

  localparam int LW = $clog2(DEPTH) + 1;

  axi_fifo_state_t       state_q, state_d;
  logic [1:0]            addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  underflow_q;

  logic [1:0]            reg_sel;
  logic                  aready_c, wready_c, rvalid_c;
  logic                  addr_load, rdata_load;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] status_snap;
  logic                  uf_set, uf_clr;
  logic                  tx_push, tx_pop, tx_flush;
  logic                  rx_push, rx_pop, rx_flush;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0]         tx_level, rx_level;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  unused_addr;

  assign reg_sel     = s_axi.addr[3:2];
  assign unused_addr = ^{s_axi.addr[ADDR_WIDTH-1:4], s_axi.addr[1:0]};

  always_comb begin
    status_snap = '0;
    status_snap[STAT_TX_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(tx_level);
    status_snap[STAT_RX_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(rx_level);
    status_snap[STAT_UNDERFLOW_BIT]            = underflow_q;
  end

  always_comb begin
    state_d    = state_q;
    aready_c   = 1'b0;
    wready_c   = 1'b0;
    rvalid_c   = 1'b0;
    addr_load  = 1'b0;
    rdata_load = 1'b0;
    rdata_d    = '0;
    uf_set     = 1'b0;
    uf_clr     = 1'b0;
    tx_push    = 1'b0;
    tx_flush   = 1'b0;
    rx_pop     = 1'b0;
    rx_flush   = 1'b0;
    case (state_q)
      IDLE: begin
        aready_c = 1'b1;
        if (s_axi.avalid) begin
          addr_load = 1'b1;
          if (s_axi.awrite) begin
            state_d = WDAT;
          end else begin
            state_d    = RRSP;
            rdata_load = 1'b1;
            case (reg_sel)
              REG_DATA: begin
                if (!rx_empty) begin
                  rx_pop  = 1'b1;
                  rdata_d = rx_head;
                end else begin
                  uf_set = 1'b1;
                end
              end
              REG_STATUS: begin
                rdata_d = status_snap;
                uf_clr  = 1'b1;
              end
              default: rdata_d = '0;
            endcase
          end
        end
      end
      WDAT: begin
        wready_c = !((addr_q == REG_DATA) && tx_full);
        if (s_axi.wvalid && wready_c) begin
          state_d = IDLE;
          case (addr_q)
            REG_DATA: tx_push = 1'b1;
            REG_CTRL: begin
              tx_flush = s_axi.wdata[CTRL_TX_FLUSH];
              rx_flush = s_axi.wdata[CTRL_RX_FLUSH];
            end
            default: ;
          endcase
        end
      end
      RRSP: begin
        rvalid_c = 1'b1;
        if (s_axi.rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= REG_DATA;
      rdata_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (addr_load)  addr_q  <= reg_sel;
      if (rdata_load) rdata_q <= rdata_d;
      // a same-cycle set outranks the STATUS read clear
      if (uf_set)      underflow_q <= 1'b1;
      else if (uf_clr) underflow_q <= 1'b0;
    end
  end

  // handshake outputs are forced low for the whole time reset is held
  assign s_axi.aready = rst_n && aready_c;
  assign s_axi.wready = rst_n && wready_c;
  assign s_axi.rvalid = rst_n && rvalid_c;
  assign s_axi.rdata  = rdata_q;

  assign tx_valid = rst_n && !tx_empty;
  assign rx_ready = rst_n && !rx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (s_axi.wdata),
    .pop       (tx_pop),
    .flush     (tx_flush),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level),
    .head      (tx_data)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .flush     (rx_flush),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level),
    .head      (rx_head)
  );

endmodule

// File: tb/tb_axi_fifo_slave.sv
// Directed bench for axi_fifo_slave with a queue-based reference model checked every cycle.
module tb_axi_fifo_slave;
  import axi_fifo_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_CTRL   = 32'h8;
  localparam logic [31:0] A_RSVD   = 32'hC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;

  axi_bus #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  axi_fifo_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_axi    (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference model: bus phase plus two word queues
  typedef enum {P_IDLE, P_WDAT, P_RRSP} phase_t;
  phase_t      m_phase = P_IDLE;
  logic [1:0]  m_reg   = 2'd0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_uf    = 1'b0;
  logic [31:0] m_txq[$];
  logic [31:0] m_rxq[$];
  logic [31:0] tx_seen[$];
  bit          started = 0;

  function automatic bit e_aready();
    return rst_n && m_phase == P_IDLE;
  endfunction
  function automatic bit e_wready();
    return rst_n && m_phase == P_WDAT && !(m_reg == 2'd0 && m_txq.size() == DEPTH);
  endfunction
  function automatic bit e_rvalid();
    return rst_n && m_phase == P_RRSP;
  endfunction
  function automatic bit e_txvalid();
    return rst_n && m_txq.size() > 0;
  endfunction
  function automatic bit e_rxready();
    return rst_n && m_rxq.size() < DEPTH;
  endfunction

  always @(posedge clk) begin
    bit tx_pop, rx_push, w_hs, tx_push, fl_tx, fl_rx;
    logic [31:0] snap;
    started = 1;
    if (!rst_n) begin
      m_txq.delete();
      m_rxq.delete();
      m_phase = P_IDLE;
      m_uf    = 1'b0;
      m_rdata = 32'h0;
    end else begin
      tx_pop  = e_txvalid() && tx_ready;
      rx_push = rx_valid && e_rxready();
      w_hs    = e_wready() && bus.wvalid;
      tx_push = 0;
      fl_tx   = 0;
      fl_rx   = 0;
      snap = (m_uf ? 32'h8000_0000 : 32'h0) | (32'(m_rxq.size()) << 12) | 32'(m_txq.size());
      case (m_phase)
        P_IDLE: if (bus.avalid) begin
          m_reg = bus.addr[3:2];
          if (bus.awrite) m_phase = P_WDAT;
          else begin
            m_phase = P_RRSP;
            if (m_reg == 2'd0) begin
              if (m_rxq.size() > 0) m_rdata = m_rxq.pop_front();
              else begin m_rdata = 32'h0; m_uf = 1'b1; end
            end else if (m_reg == 2'd1) begin
              m_rdata = snap;
              m_uf    = 1'b0;
            end else m_rdata = 32'h0;
          end
        end
        P_WDAT: if (w_hs) begin
          m_phase = P_IDLE;
          if (m_reg == 2'd0) tx_push = 1;
          else if (m_reg == 2'd2) begin
            fl_tx = bus.wdata[0];
            fl_rx = bus.wdata[1];
          end
        end
        P_RRSP: if (bus.rready) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
      if (fl_tx) m_txq.delete();
      else begin
        if (tx_pop)  void'(m_txq.pop_front());
        if (tx_push) m_txq.push_back(bus.wdata);
      end
      if (fl_rx) m_rxq.delete();
      else if (rx_push) m_rxq.push_back(rx_data);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("aready", 32'(bus.aready), 32'(e_aready()));
      check("wready", 32'(bus.wready), 32'(e_wready()));
      check("rvalid", 32'(bus.rvalid), 32'(e_rvalid()));
      check("tx_valid", 32'(tx_valid), 32'(e_txvalid()));
      check("rx_ready", 32'(rx_ready), 32'(e_rxready()));
      if (e_txvalid()) check("tx_data", tx_data, m_txq[0]);
      if (e_rvalid())  check("rdata", bus.rdata, m_rdata);
      if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit pulse_tx);
    int n;
    bus.avalid = 1'b1; bus.awrite = 1'b1; bus.addr = a;
    @(posedge clk); #1;
    bus.avalid = 1'b0; bus.awrite = 1'b0; bus.wvalid = 1'b1; bus.wdata = d;
    if (pulse_tx) tx_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      if (pulse_tx) tx_ready = 1'b0;
      n++;
    end while (m_phase != P_IDLE && n < 100);
    bus.wvalid = 1'b0;
    if (m_phase != P_IDLE) begin
      n_checks++;
      $display("FAIL write_timeout: addr %h still waiting after %0d cycles", a, n);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.avalid = 1'b1; bus.awrite = 1'b0; bus.addr = a;
    @(posedge clk); #1;
    bus.avalid = 1'b0; bus.rready = 1'b1;
    @(negedge clk);
    d = bus.rdata;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bus.avalid = 0; bus.awrite = 0; bus.addr = 0; bus.wdata = 0; bus.wvalid = 0; bus.rready = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0; rst_n = 0;
    tick(3);
    rst_n = 1;
    tick(1);
    bus_read(A_STATUS, rd); check("status_after_reset", rd, 32'h0);

    // TX drain in order
    tx_ready = 1; tx_seen.delete();
    for (int i = 0; i < 4; i++) bus_write(A_DATA, 32'hA5A5_0001 + 32'(i), 0);
    tick(3);
    check("tx_seen_count", 32'(tx_seen.size()), 32'd4);
    while (tx_seen.size() < 4) tx_seen.push_back(32'hDEAD_DEAD);
    check("tx_word0", tx_seen[0], 32'hA5A5_0001);
    check("tx_word1", tx_seen[1], 32'hA5A5_0002);
    check("tx_word2", tx_seen[2], 32'hA5A5_0003);
    check("tx_word3", tx_seen[3], 32'hA5A5_0004);
    bus_read(A_STATUS, rd); check("status_tx_drained", rd, 32'h0);

    // TX full backpressure
    tx_ready = 0; tx_seen.delete();
    for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'hB000 + 32'(i), 0);
    fork
      bus_write(A_DATA, 32'hB010, 0);
      begin tick(6); tx_ready = 1; tick(1); tx_ready = 0; end
    join
    check("tx_popped_one", 32'(tx_seen.size()), 32'd1);
    check("tx_head_after_pop", tx_data, 32'hB001);
    bus_read(A_STATUS, rd); check("status_tx_full", rd, 32'h10);
    bus_write(A_CTRL, 32'h1, 0);
    bus_read(A_STATUS, rd); check("status_tx_flushed", rd, 32'h0);

    // RX reads and underflow
    rx_push(32'h1234);
    rx_push(32'h5678);
    bus_read(A_DATA, rd); check("rx_read0", rd, 32'h1234);
    bus_read(A_DATA, rd); check("rx_read1", rd, 32'h5678);
    bus_read(A_DATA, rd); check("rx_read_empty", rd, 32'h0);
    bus_read(A_STATUS, rd); check("status_underflow", rd, 32'h8000_0000);
    bus_read(32'h7, rd); check("status_uf_cleared", rd, 32'h0);

    // RX full, pop, concurrent push/pop
    for (int i = 0; i < 16; i++) rx_push(32'h100 + 32'(i));
    check("rx_ready_full", 32'(rx_ready), 32'd0);
    bus_read(A_DATA, rd); check("rx_pop_full", rd, 32'h100);
    check("rx_ready_after_pop", 32'(rx_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      bus_read(A_DATA, rd); check("rx_drain", rd, 32'h100 + 32'(i));
    end
    rx_valid = 1; rx_data = 32'hBEEF;
    bus.avalid = 1; bus.awrite = 0; bus.addr = A_DATA;
    @(posedge clk); #1;
    rx_valid = 0; bus.avalid = 0; bus.rready = 1;
    @(negedge clk); rd = bus.rdata;
    @(posedge clk); #1; bus.rready = 0;
    check("rx_concurrent_data", rd, 32'h108);
    bus_read(A_STATUS, rd); check("status_rx_level8", rd, 32'h8000);
    bus_write(A_CTRL, 32'h2, 0);
    bus_read(A_STATUS, rd); check("status_rx_flushed", rd, 32'h0);

    // reserved and write-only registers
    bus_write(A_RSVD, 32'hFFFF_FFFF, 0);
    bus_read(A_RSVD, rd); check("rsvd_read", rd, 32'h0);
    bus_read(A_CTRL, rd); check("ctrl_read", rd, 32'h0);
    bus_read(A_STATUS, rd); check("status_after_rsvd", rd, 32'h0);

    // flush racing a stream pop
    for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'hC0 + 32'(i), 0);
    bus_read(A_STATUS, rd); check("status_tx5", rd, 32'h5);
    bus_write(A_CTRL, 32'h1, 1);
    check("tx_valid_after_flush", 32'(tx_valid), 32'd0);
    bus_read(A_STATUS, rd); check("status_flush_race", rd, 32'h0);

    // reset in WDAT with a DATA write pending
    rx_push(32'h77);
    bus_write(A_DATA, 32'h55, 0);
    bus.avalid = 1; bus.awrite = 1; bus.addr = A_DATA;
    @(posedge clk); #1;
    bus.avalid = 0; bus.awrite = 0; bus.wvalid = 1; bus.wdata = 32'h99; rst_n = 0;
    @(negedge clk);
    check("rst_wdat_aready", 32'(bus.aready), 32'd0);
    check("rst_wdat_wready", 32'(bus.wready), 32'd0);
    @(posedge clk); #1; bus.wvalid = 0;
    tick(1); rst_n = 1;
    check("rst_wdat_tx_empty", 32'(tx_valid), 32'd0);
    bus_read(A_STATUS, rd); check("status_after_rst_wdat", rd, 32'h0);

    // reset in RRSP
    rx_push(32'h66);
    rx_push(32'h67);
    bus.avalid = 1; bus.awrite = 0; bus.addr = A_DATA;
    @(posedge clk); #1;
    bus.avalid = 0; bus.rready = 1; rst_n = 0;
    @(negedge clk);
    check("rst_rrsp_rvalid", 32'(bus.rvalid), 32'd0);
    @(posedge clk); #1; bus.rready = 0; rst_n = 1;
    tick(1);
    bus_read(A_STATUS, rd); check("status_after_rst_rrsp", rd, 32'h0);
    rx_push(32'hFACE);
    bus_read(A_DATA, rd); check("rx_after_reset", rd, 32'hFACE);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
